// File: rtl/nonce_search_ctrl.sv
// nonce_search_ctrl
//   Closes the hash loop: presents a nonce plus a one-cycle load strobe to
//   concatenador_in, waits HASH_LATENCY cycles for micro_hash to produce the
//   24-bit result, and compares the two leading hash bytes against a target
//   captured at start. The search stops on the first hit or after MAX_TRIES
//   nonces, and the winning (or last tried) nonce and hash are reported.
//
// Ports
//   clk          rising-edge system clock
//   reset        asynchronous, active-low reset
//   start        one-cycle pulse, accepted only in IDLE or DONE
//   target       8-bit difficulty threshold, sampled with start
//   h_in         hash result {byte0, byte1, byte2}
//   nonce        nonce presented to concatenador_in
//   selector     one-cycle load strobe to concatenador_in
//   busy         high from the first LOAD through the last CHECK
//   done         level, high while the result is available
//   found        1 = a nonce met the target, 0 = search exhausted
//   nonce_found  winning nonce, or the last tried nonce when exhausted
//   hash_found   h_in captured for nonce_found
//   tries        nonces loaded in the current or last search
module nonce_search_ctrl #(
    parameter logic [31:0] NONCE_INIT   = 32'h0000_0000,
    parameter int unsigned HASH_LATENCY = 4,
    parameter int unsigned MAX_TRIES    = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  target,
    input  logic [23:0] h_in,
    output logic [31:0] nonce,
    output logic        selector,
    output logic        busy,
    output logic        done,
    output logic        found,
    output logic [31:0] nonce_found,
    output logic [23:0] hash_found,
    output logic [15:0] tries
);

    // MAX_TRIES = 65536 truncates to 0; tries wraps to 0 on exactly that
    // LOAD, so the 16-bit compare still terminates on the right nonce.
    localparam logic [15:0] TRIES_LAST = MAX_TRIES[15:0];
    localparam logic [7:0]  WAIT_INIT  = 8'(HASH_LATENCY - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [7:0]  target_q;
    logic [7:0]  wait_cnt;
    logic        hit;
    logic        last_try;

    assign hit      = (h_in[23:16] < target_q) && (h_in[15:8] < target_q);
    assign last_try = (tries == TRIES_LAST);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_nx = S_LOAD;
                end
            end
            S_LOAD: begin
                state_nx = S_WAIT;
            end
            S_WAIT: begin
                if (wait_cnt == '0) begin
                    state_nx = S_CHECK;
                end
            end
            S_CHECK: begin
                if (hit || last_try) begin
                    state_nx = S_DONE;
                end else begin
                    state_nx = S_LOAD;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Output decode
    always_comb begin
        selector = (state == S_LOAD);
        busy     = (state == S_LOAD) || (state == S_WAIT) || (state == S_CHECK);
        done     = (state == S_DONE);
    end

    // Search datapath
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            nonce       <= NONCE_INIT;
            target_q    <= '0;
            wait_cnt    <= '0;
            tries       <= '0;
            found       <= 1'b0;
            nonce_found <= '0;
            hash_found  <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        target_q <= target;
                        nonce    <= NONCE_INIT;
                        tries    <= '0;
                        found    <= 1'b0;
                    end
                end
                S_LOAD: begin
                    tries    <= tries + 16'd1;
                    wait_cnt <= WAIT_INIT;
                end
                S_WAIT: begin
                    if (wait_cnt != '0) begin
                        wait_cnt <= wait_cnt - 8'd1;
                    end
                end
                S_CHECK: begin
                    if (hit || last_try) begin
                        found       <= hit;
                        nonce_found <= nonce;
                        hash_found  <= h_in;
                    end else begin
                        nonce <= nonce + 32'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/nonce_search_ctrl.md
Name: nonce_search_ctrl

Overview:
- Consumer end of the hash datapath: reads the 24-bit hash result from micro_hash and compares it against the 8-bit target.
- Closes the loop by driving nonce and selector back into concatenador_in; on failure, issues the next nonce.
- Stops when a hash meets the target, or when MAX_TRIES nonces have been tried. Reports the winning nonce and hash.
- Sits between micro_hash output and concatenador_in input. Replaces the free-running nonce stimulus of the system model.

Parameters:
- NONCE_INIT, 32'h0000_0000, first nonce tried after start.
- HASH_LATENCY, 4, cycles from the selector pulse until h_in is valid for that nonce (range 1..255).
- MAX_TRIES, 256, number of nonces attempted before giving up (range 1..2^16).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low; 0 = reset.
- start  input  1  one-cycle pulse; begins a search. Ignored unless in IDLE or DONE.
- target  input  8  difficulty threshold; sampled at start.
- h_in  input  24  hash result: h_in[23:16] = H byte0, [15:8] = byte1, [7:0] = byte2.
- nonce  output  32  nonce presented to concatenador_in; byte3 = nonce[31:24].
- selector  output  1  one-cycle load strobe to concatenador_in.
- busy  output  1  high from the first LOAD through CHECK.
- done  output  1  level; high in DONE until the next start.
- found  output  1  valid while done=1: 1 = success, 0 = exhausted.
- nonce_found  output  32  nonce that met the target. Holds the last tried nonce if exhausted.
- hash_found  output  24  h_in captured for nonce_found.
- tries  output  16  nonces attempted in the current or last search.

Behaviour:
- Reset (asynchronous, while reset=0): state=IDLE; nonce=NONCE_INIT; all other outputs 0.
- States are IDLE, LOAD, WAIT, CHECK, DONE.
- IDLE/DONE, start=1 → LOAD:
  - target_q ← target; nonce ← NONCE_INIT; tries ← 0; done, found ← 0.
- LOAD (1 cycle):
  - selector=1; nonce stable.
  - tries ← tries+1; wait counter ← HASH_LATENCY−1.
  - → WAIT.
- WAIT:
  - Decrement the counter each cycle; → CHECK when the counter is 0.
  - h_in is sampled in CHECK, exactly HASH_LATENCY+1 cycles after the selector pulse (LOAD cycle + HASH_LATENCY WAIT cycles).
- CHECK (1 cycle):
  - hit = (h_in[23:16] < target_q) && (h_in[15:8] < target_q). Unsigned compare; byte2 is ignored.
  - hit → DONE with found=1; capture nonce_found=nonce, hash_found=h_in.
  - No hit and tries == MAX_TRIES → DONE with found=0; capture the same fields.
  - Otherwise nonce ← nonce+1 (wraps 32'hFFFF_FFFF → 0) → LOAD.
- DONE:
  - done=1; all result outputs held; nonce holds its last value.
  - start → LOAD (restart).
- Per-nonce period is HASH_LATENCY+2 cycles. selector is never high two consecutive cycles.
- start while busy: ignored; target changes mid-search are also ignored.
- target=0: a hit is impossible; the search always exhausts after MAX_TRIES.
- target=8'hFF: a hit occurs unless a checked byte equals 8'hFF.
- reset asserted mid-search: immediate return to IDLE; no partial result is retained.
- tries counts LOADs, including the successful one.

Test Plan:
1. Reset held low for 3 cycles, released → nonce=0, done=0, busy=0, selector=0, tries=0.
2. HASH_LATENCY=4, target=8'h10, hash model returns a hit only for nonce 3 (h_in=24'h0A05FF) → selector pulses every 6 cycles. done rises in cycle 24 after start. found=1, nonce_found=3, hash_found=24'h0A05FF, tries=4.
3. target=8'h00, MAX_TRIES=8 → exactly 8 selector pulses, then done=1, found=0, nonce_found=7, tries=8.
4. Boundary compare: h_in byte0=8'h10 equals target 8'h10 with byte1=0 → no hit. Then byte0=8'h0F → hit on that nonce.
5. NONCE_INIT=32'hFFFF_FFFE, no hits, MAX_TRIES=4 → nonces FFFF_FFFE, FFFF_FFFF, 0, 1; nonce_found=1.
6. start pulsed while busy, then reset pulled low during WAIT → start has no effect; outputs are at reset values immediately (asynchronously). A fresh start after release restarts from NONCE_INIT with tries=1 at the first LOAD.
